// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state, opcode/funct and datapath mux-select encodings
// shared by the multicycle MIPS control FSM and its datapath.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_e;

    localparam logic [5:0] HALT_OP  = 6'b111111;
    localparam logic [4:0] LINK_REG = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_LINK = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] SB_REG  = 2'b00;
    localparam logic [1:0] SB_SEXT = 2'b01;
    localparam logic [1:0] SB_ZEXT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: IR fields and Zero into the controller, enables and
// mux selects out to the datapath.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] WrDataSrc;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] State;

    modport master (
        input  Opcode, Funct, Zero,
        output PCWrite, PCSrc, IRWrite, RegWrite, RegDst, WrDataSrc,
               ALUSrcB, ALUOp, MemRead, MemWrite, State
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  PCWrite, PCSrc, IRWrite, RegWrite, RegDst, WrDataSrc,
               ALUSrcB, ALUOp, MemRead, MemWrite, State
    );
endinterface

// File: rtl/multicycle_control_alu_decode.sv
// multicycle_control_alu_decode: Opcode/Funct -> ALU operation, B-operand select,
// and whether the instruction is one that passes through EXE.
module multicycle_control_alu_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       legal
);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = SB_REG;
        legal     = 1'b1;
        case (opcode)
            OP_RTYPE: case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: legal  = 1'b0;
            endcase
            OP_ADDI, OP_LW, OP_SW: alu_src_b = SB_SEXT;
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = SB_ZEXT;
            end
            OP_BEQ:  alu_op = ALU_SUB;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EXE/MEM/WB sequencer for the multicycle MIPS core;
// the state register is the only flop, all outputs decode from it.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    multicycle_control_if.master bus
);

    state_e     state_q, state_d;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_src_b;
    logic       legal;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic [1:0] pc_src, reg_dst, wr_data, src_b;
    logic [2:0] alu_op;
    logic       is_r, is_j, is_jal, is_jr, is_beq, is_lw, is_sw, is_halt;

    multicycle_control_alu_decode u_dec (
        .opcode    (bus.Opcode),
        .funct     (bus.Funct),
        .alu_op    (dec_alu_op),
        .alu_src_b (dec_src_b),
        .legal     (legal)
    );

    assign is_r    = bus.Opcode == OP_RTYPE;
    assign is_j    = bus.Opcode == OP_J;
    assign is_jal  = bus.Opcode == OP_JAL;
    assign is_jr   = is_r && bus.Funct == FN_JR;
    assign is_beq  = bus.Opcode == OP_BEQ;
    assign is_lw   = bus.Opcode == OP_LW;
    assign is_sw   = bus.Opcode == OP_SW;
    assign is_halt = bus.Opcode == HALT_OP;

    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;

    always_comb begin
        state_d   = S_IF;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = RD_RT;
        wr_data   = WD_ALU;
        src_b     = SB_REG;
        alu_op    = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_IF: begin
                ir_write = 1'b1;
                state_d  = S_ID;
            end
            // Jumps, jr and undecodable instructions all retire here
            S_ID: begin
                state_d   = is_halt ? S_HALT : legal ? S_EXE : S_IF;
                pc_write  = !is_halt && !legal;
                pc_src    = (is_j || is_jal) ? PC_J : is_jr ? PC_JR : PC_SEQ;
                reg_write = is_jal;
                reg_dst   = is_jal ? RD_LINK : RD_RT;
                wr_data   = is_jal ? WD_PC4 : WD_ALU;
            end
            S_EXE: begin
                alu_op   = dec_alu_op;
                src_b    = dec_src_b;
                pc_write = is_beq;
                pc_src   = (is_beq && bus.Zero) ? PC_BR : PC_SEQ;
                state_d  = is_beq ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                pc_write  = is_sw;
                state_d   = is_lw ? S_WB : S_IF;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                reg_dst   = is_r ? RD_RD : RD_RT;
                wr_data   = is_lw ? WD_MEM : WD_ALU;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Reset overrides the IF decode so nothing writes while it is held
    assign bus.PCWrite   = Reset & pc_write;
    assign bus.IRWrite   = Reset & ir_write;
    assign bus.RegWrite  = Reset & reg_write;
    assign bus.MemRead   = Reset & mem_read;
    assign bus.MemWrite  = Reset & mem_write;
    assign bus.PCSrc     = Reset ? pc_src  : PC_SEQ;
    assign bus.RegDst    = Reset ? reg_dst : RD_RT;
    assign bus.WrDataSrc = Reset ? wr_data : WD_ALU;
    assign bus.ALUSrcB   = Reset ? src_b   : SB_REG;
    assign bus.ALUOp     = Reset ? alu_op  : ALU_ADD;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench checking per-cycle output traces of the multicycle control FSM
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] wd;
        logic [1:0] sb;
        logic [2:0] aop;
        logic       mr;
        logic       mw;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t idle(input logic [2:0] st);
        out_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'd0;
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z);
        out_t o;
        bit   r, alu_r, mem_op;
        r      = op == 6'h00;
        alu_r  = r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
        mem_op = op == 6'h23 || op == 6'h2b;
        o = idle(3'd0); o.irw = 1; exp_q.push_back(o);
        o = idle(3'd1);
        if (op == 6'h3f) begin
            exp_q.push_back(o);
            repeat (20) exp_q.push_back(idle(3'b111));
            return;
        end
        if (op == 6'h02 || op == 6'h03) begin
            o.pcw = 1; o.pcs = 2'b11;
            if (op == 6'h03) begin o.rw = 1; o.rd = 2'b10; o.wd = 2'b10; end
            exp_q.push_back(o);
            return;
        end
        if (r && fn == 6'h08) begin
            o.pcw = 1; o.pcs = 2'b10; exp_q.push_back(o);
            return;
        end
        if (!(alu_r || mem_op || op == 6'h08 || op == 6'h0d || op == 6'h04)) begin
            o.pcw = 1; exp_q.push_back(o);
            return;
        end
        exp_q.push_back(o);
        o = idle(3'd2);
        if (r) o.aop = alu_of(fn);
        else if (op == 6'h0d) begin o.aop = 3'd3; o.sb = 2'b10; end
        else if (op == 6'h04) begin o.aop = 3'd1; o.pcw = 1; o.pcs = z ? 2'b01 : 2'b00; end
        else o.sb = 2'b01;
        exp_q.push_back(o);
        if (op == 6'h04) return;
        if (op == 6'h2b) begin
            o = idle(3'd3); o.mw = 1; o.pcw = 1; exp_q.push_back(o);
            return;
        end
        if (op == 6'h23) begin
            o = idle(3'd3); o.mr = 1; exp_q.push_back(o);
        end
        o = idle(3'd4); o.rw = 1; o.pcw = 1;
        o.rd = r ? 2'b01 : 2'b00;
        o.wd = op == 6'h23 ? 2'b01 : 2'b00;
        exp_q.push_back(o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        bus.Opcode = op;
        bus.Funct  = fn;
        bus.Zero   = z;
        n = exp_q.size();
        plan(op, fn, z);
        n = exp_q.size() - n;
        repeat (n) tick();
    endtask

    task automatic reset_for(input int cycles);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.State !== 3'd0 || bus.PCWrite !== 1'b0 || bus.IRWrite !== 1'b0 ||
            bus.RegWrite !== 1'b0 || bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 ||
            bus.PCSrc !== 2'b00 || bus.RegDst !== 2'b00 || bus.WrDataSrc !== 2'b00 ||
            bus.ALUSrcB !== 2'b00 || bus.ALUOp !== 3'b000) begin
            n_bad++;
            $display("FAIL reset state t=%0t State=%b PCWrite=%b IRWrite=%b RegWrite=%b",
                     $time, bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite);
        end
        exp_q.delete();
        repeat (cycles) exp_q.push_back(idle(3'd0));
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        out_t a, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus.State, bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.RegWrite, bus.RegDst,
                      bus.WrDataSrc, bus.ALUSrcB, bus.ALUOp, bus.MemRead, bus.MemWrite};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs op=%b fn=%b t=%0t got=%b required=%b",
                             bus.Opcode, bus.Funct, $time, a, e);
                end
            end
        end
    end

    initial begin : driver
        logic [5:0] op, fn;
        logic [5:0] fns[7];
        logic [5:0] ops[8];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h07};
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0d, 6'h23, 6'h2b};
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h20;
        bus.Zero   = 1'b0;
        tick();
        reset_for(2);
        bus.Opcode = 6'h00; bus.Funct = 6'h20;
        plan(6'h00, 6'h20, 1'b0);
        repeat (2) tick();
        reset_for(3);
        run(6'h00, 6'h20, 1'b0);
        run(6'h23, 6'h15, 1'b0);
        run(6'h04, 6'h00, 1'b1);
        run(6'h04, 6'h00, 1'b0);
        run(6'h03, 6'h3f, 1'b1);
        run(6'h15, 6'h00, 1'b0);
        run(6'h00, 6'h07, 1'b0);
        run(6'h00, 6'h08, 1'b0);
        run(6'h3f, 6'h00, 1'b0);
        reset_for(1);
        run(6'h0d, 6'h01, 1'b0);
        run(6'h2b, 6'h20, 1'b1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin op = 6'h00; fn = fns[$urandom_range(0, 6)]; end
                2: begin
                    op = 6'h00; fn = 6'($urandom);
                end
                3: begin
                    op = 6'($urandom);
                    if (op == 6'h3f) op = 6'h3e;
                    fn = 6'($urandom);
                end
                default: begin op = ops[$urandom_range(1, 7)]; fn = 6'($urandom); end
            endcase
            if ($urandom_range(0, 39) == 0) begin
                bus.Opcode = op; bus.Funct = fn;
                plan(op, fn, 1'b0);
                tick();
                reset_for($urandom_range(1, 3));
            end else begin
                run(op, fn, 1'($urandom));
            end
        end
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL expired wait: %0d expected cycles never observed", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multicycle MIPS core. Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the write-enables and the 2-bit selects of the datapath's 4:1 muxes: PC source, register destination, write-back data and ALU B operand.
- Sits between the instruction register (IR) fields and the datapath. It is the only block that changes mux selects.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- LINK_REG, 5'd31, register written by jal (exported as constant; the datapath uses RegDst=2'b10).

Ports:
- CLK, input, 1, core clock; all state changes on the rising edge.
- Reset, input, 1, asynchronous, active-low reset.
- Opcode, input, 6, IR[31:26]; stable from the ID state onward.
- Funct, input, 6, IR[5:0].
- Zero, input, 1, ALU zero flag (valid in EXE).
- PCWrite, output, 1, PC load enable.
- PCSrc, output, 2, 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- IRWrite, output, 1, IR load enable.
- RegWrite, output, 1, register file write enable.
- RegDst, output, 2, 00 rt, 01 rd, 10 LINK_REG, 11 unused (never driven).
- WrDataSrc, output, 2, 00 ALU result, 01 memory data, 10 PC+4, 11 unused.
- ALUSrcB, output, 2, 00 B reg, 01 sign-extended imm, 10 zero-extended imm, 11 unused.
- ALUOp, output, 3, 000 add, 001 sub, 010 and, 011 or, 100 slt.
- MemRead, output, 1, data memory read.
- MemWrite, output, 1, data memory write.
- State, output, 3, current state for debug.

Behaviour:
- States: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. The State register is the only sequential element.
- Reset (Reset=0, async):
  - State=IF immediately.
  - While asserted, all enables (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) are forced to 0.
  - All selects are 00 and ALUOp is 000.
  - Reset mid-instruction abandons it; no partial write occurs after assertion.
- Outputs are combinational from State, Opcode, Funct and Zero. Default for every output in every state is 0/00.
- IF: IRWrite=1. Next state is ID.
- ID:
  - j: PCWrite=1, PCSrc=11. Next is IF.
  - jal: PCWrite=1, PCSrc=11, RegWrite=1, RegDst=10, WrDataSrc=10. Next is IF.
  - jr (R-type, Funct 001000): PCWrite=1, PCSrc=10. Next is IF.
  - HALT_OP: next is HALT.
  - Unknown opcode, or R-type with unknown funct: PCWrite=1, PCSrc=00, treated as a nop. Next is IF.
  - All others: next is EXE.
- EXE: ALUOp/ALUSrcB per instruction.
  - R-type: ALUSrcB=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Next is WB.
  - addi (001000): ALUSrcB=01, add. Next is WB.
  - ori (001101): ALUSrcB=10, or. Next is WB.
  - lw (100011) / sw (101011): ALUSrcB=01, add. Next is MEM.
  - beq (000100): ALUSrcB=00, sub, PCWrite=1. PCSrc=01 if Zero else 00. Next is IF.
- MEM:
  - lw: MemRead=1. Next is WB.
  - sw: MemWrite=1, PCWrite=1, PCSrc=00. Next is IF.
- WB: RegWrite=1, PCWrite=1, PCSrc=00. Next is IF.
  - R-type: RegDst=01, WrDataSrc=00.
  - addi/ori: RegDst=00, WrDataSrc=00.
  - lw: RegDst=00, WrDataSrc=01.
- HALT: all outputs 0. Stays in HALT until Reset.
- Latency in cycles: j/jal/jr/nop 2, beq 3, R/addi/ori/sw 4, lw 5.
- PC update rule: PCWrite is asserted exactly once per instruction, in its final state.
- One-hot invariants:
  - MemRead and MemWrite are never both 1.
  - RegWrite and MemWrite are never both 1.
  - IRWrite=1 only in IF.
- Unreachable State codes (101, 110) return to IF on the next edge with all outputs 0.

Decomposition:
- Shared package holds:
  - state encodings;
  - opcode and funct constants;
  - PCSrc/RegDst/WrDataSrc/ALUSrcB/ALUOp encodings (also used by the datapath's mux instances);
  - HALT_OP and LINK_REG.
- One natural sub-module: alu_decode. It is combinational Opcode/Funct -> ALUOp, ALUSrcB and a legal flag.

Test Plan:
- Reset low mid-EXE of add: State=000 and all enables 0 while low. After release, State goes 000->001->010->100->000; RegWrite=1 with RegDst=01 only in WB.
- lw: State sequence IF,ID,EXE,MEM,WB. ALUSrcB=01 in EXE; MemRead=1 only in MEM; WrDataSrc=01 and RegDst=00 in WB; 5 cycles total.
- beq, Zero=1 then Zero=0: EXE has ALUOp=001 and PCWrite=1, with PCSrc=01 and 00 respectively; 3 cycles.
- jal: in ID, PCSrc=11, RegDst=10, WrDataSrc=10, RegWrite=1, PCWrite=1; next state IF.
- Opcode 111111: ID->HALT; outputs stay 0 for 20 cycles; a Reset pulse returns the FSM to IF.
- Opcode 010101 and R-type funct 000111: each behaves as a nop (2 cycles, PCSrc=00, RegWrite=0, MemWrite=0).
